hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS32 pipeline.
- Generates the `stall` inputs of the IF/ID and PC pipeline registers, plus bubble/flush controls for the IF/ID and ID/EX registers.
- Detects load-use hazards and branch-taken flushes.
- Tracks the multi-cycle multiply/divide unit (MDU) with an occupancy counter, so HI/LO readers and back-to-back MDU ops are held in ID.
- Sits beside the decode stage, directly upstream of the pipeline registers it drives.

Parameters:
- MDU_LAT, 4, cycles the MDU is busy after an MDU op leaves ID; legal 1..15.
- PERF_W, 16, width of the saturating stall-event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  5  rs field of ID instruction
- id_rt  in  5  rt field of ID instruction
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_is_mdu  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_valid  in  1  EX holds a valid instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  destination of EX load
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- stall_pc  out  1  hold PC register
- stall_ifid  out  1  hold IF/ID register
- ifid_flush  out  1  load NOP into IF/ID at next edge
- idex_bubble  out  1  load NOP into ID/EX at next edge
- mdu_busy  out  1  MDU occupied
- mdu_cnt  out  4  remaining MDU busy cycles
- lu_stall_cnt  out  PERF_W  load-use stall cycles seen
- mdu_stall_cnt  out  PERF_W  MDU stall cycles seen

Behaviour:
- Reset: while rst_n=0, mdu_cnt=0 and both perf counters=0. All outputs are 0 (decode outputs forced low asynchronously). A reset arriving mid-MDU abandons the count immediately.
- load_use = ex_valid & ex_mem_read & (ex_rt!=0) & id_valid & (id_rs==ex_rt | (id_uses_rt & id_rt==ex_rt)). This term is combinational and lasts one cycle by construction.
- mdu_busy = (mdu_cnt!=0).
- mdu_hazard = id_valid & mdu_busy & (id_is_mdu | id_reads_hilo).
- hold = (load_use | mdu_hazard) & !branch_taken.
- Combinational outputs, zero-cycle latency to the pipeline registers:
  - stall_pc = hold
  - stall_ifid = hold
  - idex_bubble = hold | branch_taken
  - ifid_flush = branch_taken
- Branch priority: branch_taken overrides every hazard. PC is not stalled so it can load the target, and the ID instruction is discarded; no hazard is counted that cycle.
- MDU issue = id_valid & id_is_mdu & !hold & !branch_taken.
- MDU counter update at posedge, in priority order:
  - issue → mdu_cnt := MDU_LAT
  - else if mdu_cnt!=0 → mdu_cnt := mdu_cnt-1
  - else hold at 0
- Back-to-back MDU ops: the second op stalls until the cycle where mdu_cnt==0, then issues in that cycle and reloads MDU_LAT. There is no idle gap cycle.
- branch_taken does not cancel an MDU count already running; that op is already past ID.
- Perf counters, each incremented at posedge and saturating at 2^PERF_W-1 (no wrap):
  - lu_stall_cnt += 1 when load_use & !branch_taken
  - mdu_stall_cnt += 1 when mdu_hazard & !branch_taken
  - If both hazards are true in one cycle, both counters increment.
- ex_rt==0 never triggers load_use ($zero is not a real dependency).

Test Plan:
- Load-use, rs path: ex load with ex_rt=8, ex_valid=1, id_rs=8, id_valid=1 → stall_pc=stall_ifid=idex_bubble=1 for exactly 1 cycle; lu_stall_cnt 0→1. Repeat with ex_rt=0 → no stall.
- Load-use, rt path: id_rt=9, id_uses_rt=0 with ex_rt=9 → no stall; set id_uses_rt=1 → 1-cycle stall.
- MDU then HI/LO read, MDU_LAT=4: mult in ID at cycle 0 → mdu_cnt=4,3,2,1,0 on the following edges. An mfhi held in ID from cycle 1 stalls cycles 1–4 and issues in cycle 5; mdu_stall_cnt=4.
- Back-to-back div: second div waiting in ID issues in the cycle mdu_cnt==0, then mdu_cnt reloads to 4 at the next edge; no extra bubble.
- Branch during hazard: load_use=1 and branch_taken=1 in the same cycle → stall_pc=0, ifid_flush=1, idex_bubble=1, lu_stall_cnt unchanged. A running MDU count continues decrementing.
- Reset and saturation: drop rst_n with mdu_cnt=3 → mdu_cnt=0 and all outputs 0 immediately, without a clock edge. Separately, with PERF_W=4, hold load_use for 20 cycles → lu_stall_cnt sticks at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central stall/flush controller for the 5-stage MIPS32 pipeline. It sits
// beside the decode stage and drives the hold/flush controls of the PC,
// IF/ID and ID/EX pipeline registers.
//
// It detects three conditions:
//   - load-use hazards between a load in EX and its consumer in ID
//   - MDU occupancy hazards, where an MDU op or an mfhi/mflo in ID must wait
//     for the multi-cycle multiply/divide unit to finish
//   - taken branches/jumps resolved in EX, which flush the younger work
//
// Ports:
//   clk            pipeline clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   id_valid       ID holds a valid instruction
//   id_rs, id_rt   source register fields of the ID instruction
//   id_uses_rt     ID instruction reads rt as a source
//   id_is_mdu      ID instruction is mult/multu/div/divu
//   id_reads_hilo  ID instruction is mfhi/mflo
//   ex_valid       EX holds a valid instruction
//   ex_mem_read    EX instruction is a load
//   ex_rt          destination register of the EX load
//   branch_taken   branch/jump resolved taken in EX this cycle
//   stall_pc       hold the PC register
//   stall_ifid     hold the IF/ID register
//   ifid_flush     load a NOP into IF/ID at the next edge
//   idex_bubble    load a NOP into ID/EX at the next edge
//   mdu_busy       MDU occupied
//   mdu_cnt        remaining MDU busy cycles
//   lu_stall_cnt   saturating count of load-use stall cycles
//   mdu_stall_cnt  saturating count of MDU stall cycles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_mdu,
  input  logic              id_reads_hilo,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              branch_taken,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              mdu_busy,
  output logic [3:0]        mdu_cnt,
  output logic [PERF_W-1:0] lu_stall_cnt,
  output logic [PERF_W-1:0] mdu_stall_cnt
);

  localparam logic [3:0] LAT_VAL = 4'(MDU_LAT);

  logic load_use;
  logic mdu_hazard;
  logic hold;
  logic mdu_issue;
  logic lu_event;
  logic mdu_event;

  // Load-use detection. A load writing $zero is never a real dependency,
  // and rt only matters when the ID instruction actually reads it.
  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rt != 5'd0) & id_valid &
               ((id_rs == ex_rt) | (id_uses_rt & (id_rt == ex_rt)));
  end

  assign mdu_busy = (mdu_cnt != 4'd0);

  // MDU ops and HI/LO readers wait in ID while the unit is still occupied.
  always_comb begin
    mdu_hazard = id_valid & mdu_busy & (id_is_mdu | id_reads_hilo);
  end

  // A taken branch discards the ID instruction, so no hazard can hold the
  // front end that cycle; the PC must be free to load the target.
  always_comb begin
    hold      = (load_use | mdu_hazard) & ~branch_taken;
    mdu_issue = id_valid & id_is_mdu & ~hold & ~branch_taken;
    lu_event  = load_use & ~branch_taken;
    mdu_event = mdu_hazard & ~branch_taken;
  end

  // Decode outputs go straight to the pipeline registers with no latency.
  // They are gated by rst_n so that every output is low as soon as reset
  // asserts, without waiting for a clock edge.
  always_comb begin
    stall_pc    = rst_n & hold;
    stall_ifid  = rst_n & hold;
    idex_bubble = rst_n & (hold | branch_taken);
    ifid_flush  = rst_n & branch_taken;
  end

  // MDU occupancy counter. A fresh issue reloads the full latency; this lets
  // a waiting op issue in the very cycle the count reaches zero with no idle
  // gap. A taken branch does not touch a running count because that op has
  // already left ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= 4'd0;
    end else if (mdu_issue) begin
      mdu_cnt <= LAT_VAL;
    end else if (mdu_cnt != 4'd0) begin
      mdu_cnt <= mdu_cnt - 4'd1;
    end
  end

  // Saturating stall-event counters. Both may step in the same cycle when
  // both hazards are present at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt  <= '0;
      mdu_stall_cnt <= '0;
    end else begin
      if (lu_event && (lu_stall_cnt != '1)) begin
        lu_stall_cnt <= lu_stall_cnt + PERF_W'(1);
      end
      if (mdu_event && (mdu_stall_cnt != '1)) begin
        mdu_stall_cnt <= mdu_stall_cnt + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Directed self-checking bench for hazard_stall_ctrl. A main instance uses
// the default parameters; a second instance with PERF_W=4 shares the same
// inputs so counter saturation can be observed in a short run.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_is_mdu;
  logic        id_reads_hilo;
  logic        ex_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;

  logic        stall_pc;
  logic        stall_ifid;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mdu_busy;
  logic [3:0]  mdu_cnt;
  logic [15:0] lu_stall_cnt;
  logic [15:0] mdu_stall_cnt;

  logic        sat_stall_pc;
  logic        sat_stall_ifid;
  logic        sat_ifid_flush;
  logic        sat_idex_bubble;
  logic        sat_mdu_busy;
  logic [3:0]  sat_mdu_cnt;
  logic [3:0]  sat_lu_stall_cnt;
  logic [3:0]  sat_mdu_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl #(.MDU_LAT(4), .PERF_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_is_mdu     (id_is_mdu),
    .id_reads_hilo (id_reads_hilo),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .branch_taken  (branch_taken),
    .stall_pc      (stall_pc),
    .stall_ifid    (stall_ifid),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .mdu_busy      (mdu_busy),
    .mdu_cnt       (mdu_cnt),
    .lu_stall_cnt  (lu_stall_cnt),
    .mdu_stall_cnt (mdu_stall_cnt)
  );

  hazard_stall_ctrl #(.MDU_LAT(4), .PERF_W(4)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_is_mdu     (id_is_mdu),
    .id_reads_hilo (id_reads_hilo),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .branch_taken  (branch_taken),
    .stall_pc      (sat_stall_pc),
    .stall_ifid    (sat_stall_ifid),
    .ifid_flush    (sat_ifid_flush),
    .idex_bubble   (sat_idex_bubble),
    .mdu_busy      (sat_mdu_busy),
    .mdu_cnt       (sat_mdu_cnt),
    .lu_stall_cnt  (sat_lu_stall_cnt),
    .mdu_stall_cnt (sat_mdu_stall_cnt)
  );

  // 10 ns clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive every DUT input in one call with blocking assignments.
  task automatic applyStimulus(
    input logic       v,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt,
    input logic       is_mdu,
    input logic       reads_hilo,
    input logic       exv,
    input logic       exmr,
    input logic [4:0] exrt,
    input logic       br
  );
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_uses_rt    = uses_rt;
    id_is_mdu     = is_mdu;
    id_reads_hilo = reads_hilo;
    ex_valid      = exv;
    ex_mem_read   = exmr;
    ex_rt         = exrt;
    branch_taken  = br;
  endtask

  task automatic checkOutput(
    input string       tag,
    input logic [31:0] observed,
    input logic [31:0] expected
  );
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFront(
    input string tag,
    input logic  exp_stall,
    input logic  exp_flush,
    input logic  exp_bubble
  );
    checkOutput({tag, "_stall_pc"},    32'(stall_pc),    32'(exp_stall));
    checkOutput({tag, "_stall_ifid"},  32'(stall_ifid),  32'(exp_stall));
    checkOutput({tag, "_ifid_flush"},  32'(ifid_flush),  32'(exp_flush));
    checkOutput({tag, "_idex_bubble"}, 32'(idex_bubble), 32'(exp_bubble));
  endtask

  initial begin
    rst_n = 1'b0;
    // Hazard and branch inputs are active during reset; outputs must stay low.
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1);
    #2;
    checkFront("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset_mdu_cnt",  32'(mdu_cnt),       32'd0);
    checkOutput("reset_mdu_busy", 32'(mdu_busy),      32'd0);
    checkOutput("reset_lu_cnt",   32'(lu_stall_cnt),  32'd0);
    checkOutput("reset_mdu_scnt", 32'(mdu_stall_cnt), 32'd0);
    tick();
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Load-use via rs: one-cycle stall, counter 0 -> 1.
    $display("[TB] load-use rs path");
    applyStimulus(1'b1, 5'd8, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    #1;
    checkFront("lu_rs", 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("lu_rs_cnt", 32'(lu_stall_cnt), 32'd1);
    // Consumer now in EX (not a load); no further stall.
    applyStimulus(1'b1, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0);
    #1;
    checkFront("lu_rs_after", 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("lu_rs_after_cnt", 32'(lu_stall_cnt), 32'd1);

    // Load to $zero never stalls.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    #1;
    checkFront("lu_zero", 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("lu_zero_cnt", 32'(lu_stall_cnt), 32'd1);

    // Load-use via rt: only when rt is actually read.
    $display("[TB] load-use rt path");
    applyStimulus(1'b1, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    #1;
    checkFront("lu_rt_unused", 1'b0, 1'b0, 1'b0);
    id_uses_rt = 1'b1;
    #1;
    checkFront("lu_rt_used", 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("lu_rt_cnt", 32'(lu_stall_cnt), 32'd2);

    // Invalid EX entry does not trigger a stall.
    applyStimulus(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    #1;
    checkFront("lu_exinv", 1'b0, 1'b0, 1'b0);
    tick();

    // mult issues, then mfhi waits four cycles.
    $display("[TB] mult then mfhi");
    applyStimulus(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    checkFront("mult_issue", 1'b0, 1'b0, 1'b0);
    checkOutput("mult_busy_pre", 32'(mdu_busy), 32'd0);
    tick();
    checkOutput("mult_cnt0", 32'(mdu_cnt), 32'd4);
    checkOutput("mult_busy", 32'(mdu_busy), 32'd1);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      checkFront($sformatf("mfhi_wait%0d", i), 1'b1, 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("mfhi_cnt%0d", i), 32'(mdu_cnt), 32'(4 - i));
      checkOutput($sformatf("mfhi_scnt%0d", i), 32'(mdu_stall_cnt), 32'(i));
    end
    #1;
    checkFront("mfhi_issue", 1'b0, 1'b0, 1'b0);
    checkOutput("mfhi_busy_done", 32'(mdu_busy), 32'd0);
    tick();
    checkOutput("mfhi_scnt_final", 32'(mdu_stall_cnt), 32'd4);

    // Back-to-back div: second issues when the count hits 0, no gap.
    $display("[TB] back-to-back div");
    applyStimulus(1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("div1_cnt", 32'(mdu_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkFront($sformatf("div2_wait%0d", i), 1'b1, 1'b0, 1'b1);
      tick();
    end
    checkOutput("div2_cnt_zero", 32'(mdu_cnt), 32'd0);
    checkOutput("div2_scnt", 32'(mdu_stall_cnt), 32'd8);
    #1;
    checkFront("div2_issue", 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("div2_reload", 32'(mdu_cnt), 32'd4);

    // Both hazards together without a branch: both counters step.
    $display("[TB] dual hazard and branch priority");
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    #1;
    checkFront("dual", 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("dual_cnt", 32'(mdu_cnt), 32'd3);
    checkOutput("dual_lu", 32'(lu_stall_cnt), 32'd3);
    checkOutput("dual_mdu", 32'(mdu_stall_cnt), 32'd9);

    // Branch overrides both hazards; MDU count keeps running.
    branch_taken = 1'b1;
    #1;
    checkFront("branch", 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("branch_cnt", 32'(mdu_cnt), 32'd2);
    checkOutput("branch_lu", 32'(lu_stall_cnt), 32'd3);
    checkOutput("branch_mdu", 32'(mdu_stall_cnt), 32'd9);

    // Branch with a would-be MDU issue in ID: discarded, no reload.
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    #1;
    checkFront("branch_mdu_op", 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("branch_noissue", 32'(mdu_cnt), 32'd1);

    // Drain, issue a mult, then reset asynchronously at count 3.
    $display("[TB] asynchronous reset mid-MDU");
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("pre_reset_cnt", 32'(mdu_cnt), 32'd3);
    applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_cnt", 32'(mdu_cnt), 32'd0);
    checkOutput("areset_busy", 32'(mdu_busy), 32'd0);
    checkOutput("areset_lu", 32'(lu_stall_cnt), 32'd0);
    checkOutput("areset_mdu", 32'(mdu_stall_cnt), 32'd0);
    checkFront("areset", 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Hold load-use for 20 cycles: 4-bit counter saturates at 15.
    $display("[TB] saturation");
    applyStimulus(1'b1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    checkOutput("sat_lu_4bit", 32'(sat_lu_stall_cnt), 32'd15);
    checkOutput("sat_lu_16bit", 32'(lu_stall_cnt), 32'd20);
    checkOutput("sat_stall_pc", 32'(sat_stall_pc), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
